sensor_tdc_accum: RTL and testbench

SENSOR_TDC_ACCUM -- requirements
Module: sensor_tdc_accum

---
 rtl/sensor_pkg.sv | 20 ++
 rtl/sensor_therm2bin.sv | 30 +++
 rtl/sensor_tdc_accum.sv | 241 ++++++++++++++++++++++++
 tb/tb_sensor_tdc_accum.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared types and constants for the TDC snapshot accumulator.
package sensor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SYNC_CYCLES = 2;
    localparam int RESULT_W    = 8;
    localparam int RESULT_MAX  = (1 << RESULT_W) - 1;

    // Bits needed to hold a thermometer code of 0..n_taps.
    function automatic int code_width(input int n_taps);
        return $clog2(n_taps + 1);
    endfunction

endpackage

// File: rtl/sensor_therm2bin.sv
// Combinational thermometer-to-count decoder with bubble detection.
module sensor_therm2bin #(
    parameter int N_TAPS = 8
) (
    input  logic [N_TAPS-1:0]             i_tap,
    output logic [$clog2(N_TAPS+1)-1:0]   o_code,
    output logic                          o_bubble
);

    localparam int CODE_W = $clog2(N_TAPS + 1);

    logic w_seen_zero;

    // Count ones from bit 0 until the first zero; any one past it is a bubble.
    always_comb begin
        o_code      = {CODE_W{1'b0}};
        o_bubble    = 1'b0;
        w_seen_zero = 1'b0;
        for (int i = 0; i < N_TAPS; i++) begin
            if (!i_tap[i]) begin
                w_seen_zero = 1'b1;
            end else if (w_seen_zero) begin
                o_bubble = 1'b1;
            end else begin
                o_code = o_code + CODE_W'(1);
            end
        end
    end

endmodule

// File: rtl/sensor_tdc_accum.sv
// Averages 2^LOG2_SAMPLES synchronised delay-line snapshots into one code sum.
// Optional feature macro: SENSOR_MINMAX_EN adds per-measurement min/max codes.
module sensor_tdc_accum
    import sensor_pkg::*;
#(
    parameter int N_TAPS       = 8,
    parameter int LOG2_SAMPLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_TAPS-1:0]            tap,
    input  logic                         start,
    output logic                         busy,
    output logic                         valid,
    output logic [RESULT_W-1:0]          result,
    output logic                         bubble_err
`ifdef SENSOR_MINMAX_EN
    ,
    output logic [$clog2(N_TAPS+1)-1:0]  min_code,
    output logic [$clog2(N_TAPS+1)-1:0]  max_code
`endif
);

    localparam int CODE_W = code_width(N_TAPS);
    localparam int ACC_W  = CODE_W + LOG2_SAMPLES;
    localparam int CNT_W  = LOG2_SAMPLES + 1;
    // One spare bit keeps the saturation compare from degenerating to a constant.
    localparam int SUM_W  = ((ACC_W > RESULT_W) ? ACC_W : RESULT_W) + 1;

    logic [N_TAPS-1:0]   r_tap_meta;
    logic [N_TAPS-1:0]   r_tap_sync;
    logic [CODE_W-1:0]   w_code;
    logic                w_bubble;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_sync_last;
    logic                w_accum_last;

    logic                w_start_accept;
    logic                w_acc_en;
    logic                w_load_result;
    logic                w_busy_nxt;

    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_sum;
    logic [SUM_W-1:0]    w_sum_ext;
    logic [RESULT_W-1:0] w_result_sat;

    logic                r_busy;
    logic                r_valid;
    logic [RESULT_W-1:0] r_result;
    logic                r_bubble;

    // Two-flop synchroniser for the asynchronous tap snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tap_meta <= {N_TAPS{1'b0}};
            r_tap_sync <= {N_TAPS{1'b0}};
        end else begin
            r_tap_meta <= tap;
            r_tap_sync <= r_tap_meta;
        end
    end

    sensor_therm2bin #(
        .N_TAPS (N_TAPS)
    ) u_therm2bin (
        .i_tap    (r_tap_sync),
        .o_code   (w_code),
        .o_bubble (w_bubble)
    );

    assign w_sync_last  = (r_cnt == CNT_W'(SYNC_CYCLES - 1));
    assign w_accum_last = (r_cnt == CNT_W'((1 << LOG2_SAMPLES) - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_SYNC;
                else       w_state_nxt = ST_IDLE;
            end
            ST_SYNC: begin
                if (w_sync_last) w_state_nxt = ST_ACCUM;
                else             w_state_nxt = ST_SYNC;
            end
            ST_ACCUM: begin
                if (w_accum_last) w_state_nxt = ST_DONE;
                else              w_state_nxt = ST_ACCUM;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode; result and valid are loaded on the last ACCUM edge so
    // they are visible throughout the DONE cycle.
    always_comb begin
        w_start_accept = 1'b0;
        w_acc_en       = 1'b0;
        w_load_result  = 1'b0;
        w_busy_nxt     = (w_state_nxt != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                w_start_accept = start;
            end
            ST_SYNC: begin
                w_acc_en = 1'b0;
            end
            ST_ACCUM: begin
                w_acc_en      = 1'b1;
                w_load_result = w_accum_last;
            end
            ST_DONE: begin
                w_acc_en = 1'b0;
            end
            default: begin
                w_acc_en = 1'b0;
            end
        endcase
    end

    // Phase counter, restarted on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_state != w_state_nxt) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == ST_SYNC) || (r_state == ST_ACCUM)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= {CNT_W{1'b0}};
        end
    end

    assign w_acc_sum = r_acc + ACC_W'(w_code);

    // Saturate the final sum to the result width.
    always_comb begin
        w_sum_ext = SUM_W'(w_acc_sum);
        if (w_sum_ext > SUM_W'(RESULT_MAX)) begin
            w_result_sat = {RESULT_W{1'b1}};
        end else begin
            w_result_sat = w_sum_ext[RESULT_W-1:0];
        end
    end

    // Accumulator, result, status outputs and sticky bubble flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= {ACC_W{1'b0}};
            r_result <= {RESULT_W{1'b0}};
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_bubble <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_valid <= w_load_result;
            if (w_start_accept) begin
                r_acc <= {ACC_W{1'b0}};
            end else if (w_acc_en) begin
                r_acc <= w_acc_sum;
            end else begin
                r_acc <= r_acc;
            end
            if (w_load_result) begin
                r_result <= w_result_sat;
            end else begin
                r_result <= r_result;
            end
            if (w_start_accept) begin
                r_bubble <= 1'b0;
            end else if (w_acc_en && w_bubble) begin
                r_bubble <= 1'b1;
            end else begin
                r_bubble <= r_bubble;
            end
        end
    end

    assign busy       = r_busy;
    assign valid      = r_valid;
    assign result     = r_result;
    assign bubble_err = r_bubble;

`ifdef SENSOR_MINMAX_EN
    logic [CODE_W-1:0] r_min_trk;
    logic [CODE_W-1:0] r_max_trk;
    logic [CODE_W-1:0] r_min_code;
    logic [CODE_W-1:0] r_max_code;
    logic [CODE_W-1:0] w_min_upd;
    logic [CODE_W-1:0] w_max_upd;

    assign w_min_upd = (w_code < r_min_trk) ? w_code : r_min_trk;
    assign w_max_upd = (w_code > r_max_trk) ? w_code : r_max_trk;

    // Min/max code tracking across ACCUM, published together with result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_min_trk  <= CODE_W'(N_TAPS);
            r_max_trk  <= {CODE_W{1'b0}};
            r_min_code <= {CODE_W{1'b0}};
            r_max_code <= {CODE_W{1'b0}};
        end else begin
            if (w_start_accept) begin
                r_min_trk <= CODE_W'(N_TAPS);
                r_max_trk <= {CODE_W{1'b0}};
            end else if (w_acc_en) begin
                r_min_trk <= w_min_upd;
                r_max_trk <= w_max_upd;
            end else begin
                r_min_trk <= r_min_trk;
                r_max_trk <= r_max_trk;
            end
            if (w_load_result) begin
                r_min_code <= w_min_upd;
                r_max_code <= w_max_upd;
            end else begin
                r_min_code <= r_min_code;
                r_max_code <= r_max_code;
            end
        end
    end

    assign min_code = r_min_code;
    assign max_code = r_max_code;
`endif

endmodule

// File: tb/tb_sensor_tdc_accum.sv
// Directed-vector bench for sensor_tdc_accum (default parameters).
module tb_sensor_tdc_accum;

    logic       clk;
    logic       rst;
    logic [7:0] tap;
    logic       start;
    logic       busy;
    logic       valid;
    logic [7:0] result;
    logic       bubble_err;
`ifdef SENSOR_MINMAX_EN
    logic [3:0] min_code;
    logic [3:0] max_code;
`endif

    int n_vec;
    int n_mis;

    sensor_tdc_accum #(
        .N_TAPS       (8),
        .LOG2_SAMPLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tap        (tap),
        .start      (start),
        .busy       (busy),
        .valid      (valid),
        .result     (result),
        .bubble_err (bubble_err)
`ifdef SENSOR_MINMAX_EN
        ,
        .min_code   (min_code),
        .max_code   (max_code)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts one measurement and watches 40 cycles. Cycle c is the period after
    // edge c-1, with edge 0 sampling start. With alt set, tap alternates ta/tb.
    task automatic run_meas(input logic [7:0] ta, input logic [7:0] tb, input bit alt,
                            input bit restart, output int lat, output int npulse,
                            output logic busy1, output logic bub1);
        lat    = 0;
        npulse = 0;
        tap    = ta;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                busy1 = busy;
                bub1  = bubble_err;
            end
            if (valid) begin
                npulse++;
                if (lat == 0) lat = c;
            end
            start = (restart && ((c == 1) || (c == 10))) ? 1'b1 : 1'b0;
            if (alt) tap = (c % 2 == 1) ? tb : ta;
        end
        start = 1'b0;
    endtask

    task automatic std_meas(input string tag, input logic [7:0] tv,
                            input logic [7:0] exp_res, input logic exp_bub);
        int   lat;
        int   np;
        logic b1;
        logic bb1;
        run_meas(tv, tv, 1'b0, 1'b0, lat, np, b1, bb1);
        check_eq({tag, "_latency"}, lat, 32'd19);
        check_eq({tag, "_pulses"}, np, 32'd1);
        check_eq({tag, "_busy_c1"}, {31'd0, b1}, 32'd1);
        check_eq({tag, "_bub_c1"}, {31'd0, bb1}, 32'd0);
        check_eq({tag, "_result"}, {24'd0, result}, {24'd0, exp_res});
        check_eq({tag, "_bubble"}, {31'd0, bubble_err}, {31'd0, exp_bub});
        check_eq({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int   lat;
        int   np;
        logic b1;
        logic bb1;
        n_vec = 0;
        n_mis = 0;
        rst   = 1'b1;
        start = 1'b0;
        tap   = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        check_eq("rst_result", {24'd0, result}, 32'd0);
        check_eq("rst_bubble", {31'd0, bubble_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        std_meas("t0F", 8'h0F, 8'h40, 1'b0);
        std_meas("tFF", 8'hFF, 8'h80, 1'b0);
        std_meas("t00", 8'h00, 8'h00, 1'b0);
        std_meas("t0B", 8'h0B, 8'h20, 1'b1);
        repeat (5) @(negedge clk);
        check_eq("t0B_bubble_held", {31'd0, bubble_err}, 32'd1);
        check_eq("t0B_result_held", {24'd0, result}, 32'h20);
        std_meas("t0F_after_bubble", 8'h0F, 8'h40, 1'b0);

        // Abort in the 5th ACCUM cycle (cycle 7) after a prior result of 0x40.
        tap = 8'hFF;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        np = 0;
        for (int c = 0; c < 25; c++) begin
            if (valid) np++;
            @(negedge clk);
        end
        check_eq("abort_pulses", np, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_result", {24'd0, result}, 32'd0);
        std_meas("t0F_after_abort", 8'h0F, 8'h40, 1'b0);

        run_meas(8'h07, 8'h07, 1'b0, 1'b1, lat, np, b1, bb1);
        check_eq("restart_latency", lat, 32'd19);
        check_eq("restart_pulses", np, 32'd1);
        check_eq("restart_result", {24'd0, result}, 32'h30);

`ifdef SENSOR_MINMAX_EN
        run_meas(8'h03, 8'h3F, 1'b1, 1'b0, lat, np, b1, bb1);
        check_eq("mm_latency", lat, 32'd19);
        check_eq("mm_result", {24'd0, result}, 32'h40);
        check_eq("mm_min", {28'd0, min_code}, 32'd2);
        check_eq("mm_max", {28'd0, max_code}, 32'd6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
